// File: rtl/mcs4_ram_bus_master.sv
// mcs4_ram_bus_master: issues SRC + I/O cycles to 4002 RAMs; MCS4_SRC_CACHE_EN skips SRC on a repeated address
module mcs4_ram_bus_master #(
    parameter bit RSP_ON_WRITE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [3:0] req_op_i,
    input  logic [1:0] req_chip_i,
    input  logic [1:0] req_reg_i,
    input  logic [3:0] req_char_i,
    input  logic [3:0] req_data_i,
    output logic       rsp_valid_o,
    output logic [3:0] rsp_data_o,
    output logic       sync_o,
    output logic       cm_ram_o,
    output logic [3:0] dbus_out_o,
    input  logic [3:0] dbus_in_i
);
    localparam logic [2:0] PH_M2 = 3'd4;
    localparam logic [2:0] PH_X2 = 3'd6;
    localparam logic [2:0] PH_X3 = 3'd7;

    typedef enum logic [1:0] {IDLE, SRC, IO} state_t;

    state_t     state_q, state_d;
    logic [2:0] phase_q;
    logic       busy_q, busy_d;
    logic [3:0] op_q, op_d, char_q, char_d, data_q, data_d, rsp_data_q, rsp_data_d;
    logic [1:0] chip_q, chip_d, reg_q, reg_d;
    logic       cyc_end, accept, hit;
`ifdef MCS4_SRC_CACHE_EN
    logic [7:0] cache_q, cache_d;
    logic       cache_vld_q, cache_vld_d;
`endif

    assign cyc_end     = phase_q == PH_X3;
    assign req_ready_o = !rst && (!busy_q || (state_q == IO && cyc_end));
    assign accept      = req_valid_i && req_ready_o;

    // Request capture, command sequencing and read-data sampling
    always_comb begin
        op_d       = accept ? req_op_i : op_q;
        chip_d     = accept ? req_chip_i : chip_q;
        reg_d      = accept ? req_reg_i : reg_q;
        char_d     = accept ? req_char_i : char_q;
        data_d     = accept ? req_data_i : data_q;
        busy_d     = accept || (busy_q && !(state_q == IO && cyc_end));
        rsp_data_d = (state_q == IO && phase_q == PH_X2 && op_q[3]) ? dbus_in_i : rsp_data_q;
`ifdef MCS4_SRC_CACHE_EN
        hit         = cache_vld_q && {chip_d, reg_d, char_d} == cache_q;
        cache_d     = (state_q == SRC && cyc_end) ? {chip_q, reg_q, char_q} : cache_q;
        cache_vld_d = cache_vld_q || (state_q == SRC && cyc_end);
`else
        hit         = 1'b0;
`endif
        state_d    = state_q;
        if (cyc_end)
            state_d = state_q == SRC ? IO : busy_d ? (hit ? IO : SRC) : IDLE;
    end

    // State registers; the phase counter free-runs and parks at X3 in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_X3;
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            op_q       <= 4'd0;
            chip_q     <= 2'd0;
            reg_q      <= 2'd0;
            char_q     <= 4'd0;
            data_q     <= 4'd0;
            rsp_data_q <= 4'd0;
        end else begin
            phase_q    <= phase_q + 3'd1;
            state_q    <= state_d;
            busy_q     <= busy_d;
            op_q       <= op_d;
            chip_q     <= chip_d;
            reg_q      <= reg_d;
            char_q     <= char_d;
            data_q     <= data_d;
            rsp_data_q <= rsp_data_d;
        end
    end

`ifdef MCS4_SRC_CACHE_EN
    // Address of the last SRC actually sent on the bus
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_q     <= 8'd0;
            cache_vld_q <= 1'b0;
        end else begin
            cache_q     <= cache_d;
            cache_vld_q <= cache_vld_d;
        end
    end
`endif

    assign sync_o      = cyc_end;
    assign rsp_valid_o = state_q == IO && cyc_end && (op_q[3] || RSP_ON_WRITE);
    assign rsp_data_o  = rsp_data_q;
    assign cm_ram_o    = (state_q == SRC && phase_q >= PH_X2) || (state_q == IO && phase_q == PH_M2);
    assign dbus_out_o  = (state_q == SRC && phase_q == PH_X2)           ? {chip_q, reg_q} :
                         (state_q == SRC && cyc_end)                    ? char_q :
                         (state_q == IO && phase_q == PH_M2)            ? op_q :
                         (state_q == IO && phase_q == PH_X2 && !op_q[3]) ? data_q : 4'd0;
endmodule

// File: tb/tb_mcs4_ram_bus_master.sv
// tb_mcs4_ram_bus_master: bus master driving a behavioural bank of four 4002 RAM chips
module tb_mcs4_ram_bus_master;
`ifdef MCS4_SRC_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    logic       clk, rst, req_valid, req_ready, rsp_valid, sync, cm_ram;
    logic [3:0] req_op, req_char, req_data, rsp_data, dbus_out, dbus_in;
    logic [1:0] req_chip, req_reg;
    int         n_chk, n_err;

    mcs4_ram_bus_master dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_chip_i(req_chip), .req_reg_i(req_reg),
        .req_char_i(req_char), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .sync_o(sync), .cm_ram_o(cm_ram), .dbus_out_o(dbus_out), .dbus_in_i(dbus_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Four 4002 chips: phase from sync, SRC seen by cm_ram at X2/X3, I/O opcode by cm_ram at M2
    logic [2:0] mph;
    logic [1:0] m_chip, m_reg;
    logic [3:0] m_char, m_op, rd_val;
    logic       m_io;
    logic [3:0] mem  [4][4][16];
    logic [3:0] stat [4][4][4];

    initial begin
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                for (int c = 0; c < 16; c++) mem[a][b][c] = 4'd0;
                for (int c = 0; c < 4; c++) stat[a][b][c] = 4'd0;
            end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mph  <= 3'd7;
            m_io <= 1'b0;
        end else begin
            mph <= sync ? 3'd0 : mph + 3'd1;
            if (cm_ram && mph == 3'd6) {m_chip, m_reg} <= dbus_out;
            if (cm_ram && mph == 3'd7) m_char <= dbus_out;
            if (cm_ram && mph == 3'd4) begin
                m_op <= dbus_out;
                m_io <= 1'b1;
            end else if (mph == 3'd7) m_io <= 1'b0;
            if (m_io && mph == 3'd6 && !m_op[3]) begin
                if (m_op == 4'h0) mem[m_chip][m_reg][m_char] <= dbus_out;
                else if (m_op[3:2] == 2'b01) stat[m_chip][m_reg][m_op[1:0]] <= dbus_out;
            end
        end
    end

    assign rd_val  = m_op == 4'h9 ? mem[m_chip][m_reg][m_char] :
                     m_op[3:2] == 2'b11 ? stat[m_chip][m_reg][m_op[1:0]] : 4'd0;
    assign dbus_in = (m_io && mph == 3'd6 && m_op[3]) ? rd_val : 4'd0;

    typedef struct {
        logic [3:0] op;
        logic [1:0] chip;
        logic [1:0] rg;
        logic [3:0] ch;
        logic [3:0] d;
        logic [3:0] exp;
    } vec_t;

    vec_t       vec [13];
    logic [7:0] ca;
    bit         cv;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_req(input logic [3:0] op, input logic [1:0] c, input logic [1:0] r,
                          input logic [3:0] ch, input logic [3:0] d,
                          output logic [3:0] rd, output int lat, output int k, output bit src);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ready wait", int'(req_ready), 1);
        req_op = op; req_chip = c; req_reg = r; req_char = ch; req_data = d; req_valid = 1'b1;
        k = int'(mph);
        @(posedge clk);
        #1 req_valid = 1'b0;
        src = 1'b0; lat = 99; rd = 4'd0;
        for (int m = 1; m <= 40; m++) begin
            @(negedge clk);
            if (cm_ram && mph == 3'd6) src = 1'b1;
            if (rsp_valid) begin
                lat = m;
                rd  = rsp_data;
                break;
            end
        end
    endtask

    task automatic run(input string nm, input logic [3:0] op, input logic [1:0] c, input logic [1:0] r,
                       input logic [3:0] ch, input logic [3:0] d, input logic [3:0] exp);
        logic [3:0] rd;
        int         lat, k;
        bit         src, hit;
        hit = CACHE && cv && {c, r, ch} == ca;
        do_req(op, c, r, ch, d, rd, lat, k, src);
        check({nm, " latency"}, lat, (hit ? 15 : 23) - k);
        check({nm, " src issued"}, int'(src), int'(!hit));
        if (op[3]) check({nm, " rsp_data"}, int'(rd), int'(exp));
        if (!hit) begin
            ca = {c, r, ch};
            cv = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int nr, last, ns, bad, i;
        int rt [8];
        bit acc, found;
        n_chk = 0; n_err = 0; cv = 1'b0; ca = 8'd0;
        rst = 1'b1; req_valid = 1'b0;
        req_op = 4'd0; req_chip = 2'd0; req_reg = 2'd0; req_char = 4'd0; req_data = 4'd0;
        vec[0]  = '{4'h0, 2'd2, 2'd1, 4'd5,  4'hA, 4'h0};
        vec[1]  = '{4'h9, 2'd2, 2'd1, 4'd5,  4'h0, 4'hA};
        vec[2]  = '{4'h9, 2'd0, 2'd1, 4'd5,  4'h0, 4'h0};
        vec[3]  = '{4'h9, 2'd1, 2'd1, 4'd5,  4'h0, 4'h0};
        vec[4]  = '{4'h9, 2'd3, 2'd1, 4'd5,  4'h0, 4'h0};
        vec[5]  = '{4'h6, 2'd0, 2'd3, 4'd0,  4'h7, 4'h0};
        vec[6]  = '{4'hE, 2'd0, 2'd3, 4'd0,  4'h0, 4'h7};
        vec[7]  = '{4'hD, 2'd0, 2'd3, 4'd0,  4'h0, 4'h0};
        vec[8]  = '{4'h0, 2'd3, 2'd2, 4'd15, 4'h5, 4'h0};
        vec[9]  = '{4'h9, 2'd3, 2'd2, 4'd15, 4'h0, 4'h5};
        vec[10] = '{4'h9, 2'd3, 2'd2, 4'd14, 4'h0, 4'h0};
        vec[11] = '{4'h4, 2'd1, 2'd0, 4'd0,  4'h9, 4'h0};
        vec[12] = '{4'hC, 2'd1, 2'd0, 4'd0,  4'h0, 4'h9};

        @(negedge clk);
        check("reset sync", int'(sync), 1);
        check("reset cm_ram", int'(cm_ram), 0);
        check("reset dbus_out", int'(dbus_out), 0);
        check("reset rsp_valid", int'(rsp_valid), 0);
        check("reset rsp_data", int'(rsp_data), 0);
        check("reset req_ready", int'(req_ready), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 13; v++)
            run($sformatf("vec%0d", v), vec[v].op, vec[v].chip, vec[v].rg, vec[v].ch, vec[v].d, vec[v].exp);

        // Eight back-to-back writes with req_valid held high
        @(negedge clk);
        i = 0; nr = 0; last = -1; ns = 0; bad = 0;
        req_op = 4'h0; req_chip = 2'd0; req_reg = 2'd2; req_char = 4'd8; req_data = 4'd1; req_valid = 1'b1;
        for (int c = 0; c < 160; c++) begin
            if (rsp_valid && nr < 8) begin
                rt[nr] = c;
                nr++;
            end
            if (sync) begin
                if (last >= 0 && c - last != 8) bad++;
                last = c;
                ns++;
            end
            acc = req_valid && req_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                i++;
                if (i == 8) req_valid = 1'b0;
                else begin
                    req_chip = 2'(i); req_char = 4'(8 + i); req_data = 4'(i + 1);
                end
            end
            @(negedge clk);
        end
        check("b2b accepted", i, 8);
        check("b2b responses", nr, 8);
        for (int j = 1; j < 8; j++) check($sformatf("b2b gap%0d", j), rt[j] - rt[j-1], 16);
        check("b2b sync gaps off", bad, 0);
        check("b2b sync count", ns, 20);
        ca = {2'd3, 2'd2, 4'd15}; cv = 1'b1;
        run("b2b rd1", 4'h9, 2'd1, 2'd2, 4'd9, 4'h0, 4'h2);
        run("b2b rd7", 4'h9, 2'd3, 2'd2, 4'd15, 4'h0, 4'h8);

        // Reset at M2 of the IO cycle of a WRM 0xF
        while (!req_ready) @(negedge clk);
        req_op = 4'h0; req_chip = 2'd2; req_reg = 2'd1; req_char = 4'd5; req_data = 4'hF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (cm_ram && mph == 3'd4) found = 1'b1;
        end
        check("rst io m2 reached", int'(found), 1);
        rst = 1'b1;
        #1;
        check("rst sync", int'(sync), 1);
        check("rst cm_ram", int'(cm_ram), 0);
        check("rst dbus_out", int'(dbus_out), 0);
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (!sync || rsp_valid) bad++;
        end
        check("rst held outputs", bad, 0);
        rst = 1'b0;
        cv = 1'b0;
        nr = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) nr++;
        end
        check("rst dropped rsp", nr, 0);
        run("rst readback", 4'h9, 2'd2, 2'd1, 4'd5, 4'h0, 4'hA);

        // Idle: sync every 8 clocks, bus quiet
        bad = 0; ns = 0; last = -1; i = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (cm_ram || dbus_out != 4'd0) bad++;
            if (sync) begin
                if (last >= 0 && c - last != 8) i++;
                last = c;
                ns++;
            end
        end
        check("idle bus activity", bad, 0);
        check("idle sync gaps off", i, 0);
        check("idle sync count", ns, 5);

        // Repeated read of one address: SRC skipped only with the cache
        run("rep rd a", 4'h9, 2'd0, 2'd2, 4'd3, 4'h0, 4'h0);
        run("rep rd b", 4'h9, 2'd0, 2'd2, 4'd3, 4'h0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
